// File: rtl/boot_mem_arbiter_if.sv
// Bundle between the boot loader/arbiter, the UART receiver, the pipeline and the memory.
// Latency: none, wires only.
// Backpressure: none; rx_valid is a strobe and every strobed byte must be taken.
// Ports:
//   rx_data/rx_valid             : byte stream from the UART receiver
//   cpu_wren/wmask/wdata/addr    : pipeline memory request
//   cpu_rstn                     : pipeline reset, released once the image is loaded
//   mem_wren/wmask/wdata/addr    : muxed memory port
//   busy/err                     : loader status
interface boot_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 11
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  cpu_wren;
  logic [3:0]            cpu_wmask;
  logic [31:0]           cpu_wdata;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic                  cpu_rstn;
  logic                  mem_wren;
  logic [3:0]            mem_wmask;
  logic [31:0]           mem_wdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  busy;
  logic                  err;

  // Environment side: UART, pipeline and memory as seen from outside the arbiter.
  modport master (
    output rx_data, rx_valid, cpu_wren, cpu_wmask, cpu_wdata, cpu_addr,
    input  cpu_rstn, mem_wren, mem_wmask, mem_wdata, mem_addr, busy, err
  );

  // Arbiter side.
  modport slave (
    input  rx_data, rx_valid, cpu_wren, cpu_wmask, cpu_wdata, cpu_addr,
    output cpu_rstn, mem_wren, mem_wmask, mem_wdata, mem_addr, busy, err
  );
endinterface

// File: rtl/boot_mem_arbiter.sv
// UART boot loader that writes an image into instruction memory, then hands the port to the pipeline.
// Latency: 4th byte of a word at edge N -> memory write in cycle N..N+1; RUN passthrough is combinational.
// Backpressure: none; a byte may arrive every cycle and is always accepted (ignored in RUN/ERROR).
// Ports: clk, rstn (synchronous, active-low), bus (slave modport of boot_mem_arbiter_if).
module boot_mem_arbiter #(
  parameter int         ADDR_WIDTH = 11,
  parameter logic [7:0] SYNC_BYTE  = 8'hB5
) (
  input logic               clk,
  input logic               rstn,
  boot_mem_arbiter_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_RUN, S_ERROR
  } state_t;

  state_t                state;
  logic [15:0]           count;
  // One bit wider than the address so a full-depth image count is representable.
  logic [ADDR_WIDTH:0]   word_idx;
  logic [1:0]            byte_idx;
  logic [23:0]           asm_word;
  logic                  wr_vld;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  // Set for the one cycle before entering RUN: either the last word's write
  // cycle or the cycle after an empty-image length. Bytes are dropped meanwhile.
  logic                  finish_q;
  logic                  cpu_rstn_q;

  logic [15:0]           len_full;
  logic [ADDR_WIDTH:0]   word_nxt;

  assign len_full = {bus.rx_data, count[7:0]};
  assign word_nxt = word_idx + {{ADDR_WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_SYNC;
      count      <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      asm_word   <= '0;
      wr_vld     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      finish_q   <= 1'b0;
      cpu_rstn_q <= 1'b0;
    end else begin
      wr_vld <= 1'b0;
      if (finish_q) begin
        finish_q   <= 1'b0;
        state      <= S_RUN;
        cpu_rstn_q <= 1'b1;
      end else if (bus.rx_valid) begin
        case (state)
          S_SYNC: begin
            if (bus.rx_data == SYNC_BYTE) state <= S_LEN_LO;
          end
          S_LEN_LO: begin
            count[7:0] <= bus.rx_data;
            state      <= S_LEN_HI;
          end
          S_LEN_HI: begin
            count[15:8] <= bus.rx_data;
            if (len_full == 16'd0) begin
              finish_q <= 1'b1;
            end else if (32'(len_full) > DEPTH) begin
              state <= S_ERROR;
            end else begin
              state    <= S_DATA;
              word_idx <= '0;
              byte_idx <= '0;
            end
          end
          S_DATA: begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: asm_word[7:0]   <= bus.rx_data;
              2'd1: asm_word[15:8]  <= bus.rx_data;
              2'd2: asm_word[23:16] <= bus.rx_data;
              default: begin
                wr_vld   <= 1'b1;
                wr_data  <= {bus.rx_data, asm_word};
                wr_addr  <= word_idx[ADDR_WIDTH-1:0];
                word_idx <= word_nxt;
                if (32'(word_nxt) == 32'(count)) finish_q <= 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  // The pipeline only sees the port once the state register says RUN, so a
  // loader write and a pipeline access can never share a cycle.
  always_comb begin
    if (state == S_RUN) begin
      bus.mem_wren  = bus.cpu_wren;
      bus.mem_wmask = bus.cpu_wmask;
      bus.mem_wdata = bus.cpu_wdata;
      bus.mem_addr  = bus.cpu_addr;
    end else begin
      bus.mem_wren  = wr_vld;
      bus.mem_wmask = wr_vld ? 4'hF : 4'h0;
      bus.mem_wdata = wr_vld ? wr_data : 32'd0;
      bus.mem_addr  = wr_vld ? wr_addr : '0;
    end
  end

  assign bus.cpu_rstn = cpu_rstn_q;
  assign bus.busy     = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA);
  assign bus.err      = (state == S_ERROR);

endmodule

// File: tb/tb_boot_mem_arbiter.sv
// Directed bench for boot_mem_arbiter: image load, noise/empty image, overlength,
// passthrough, reset mid-transfer and a full-depth back-to-back load.
module tb_boot_mem_arbiter;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b1;

  logic [10:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [3:0]  wr_mask_q[$];

  boot_mem_arbiter_if #(.ADDR_WIDTH(11)) bus ();

  boot_mem_arbiter #(.ADDR_WIDTH(11), .SYNC_BYTE(8'hB5)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Record every memory write, sampled away from the active edge.
  always @(negedge clk) begin
    if (mon_en && bus.mem_wren) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
      wr_mask_q.push_back(bus.mem_wmask);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte is sampled at the next rising edge; returns 1 time unit after it.
  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_mask_q.delete();
  endtask

  function automatic logic [31:0] img_word(input int i);
    logic [7:0] a, b, c, d;
    a = 8'(i);
    b = 8'(i * 3);
    c = 8'(i >> 3) ^ 8'h5A;
    d = ~8'(i);
    return {c, a, b, d};
  endfunction

  initial begin
    logic [31:0] w;
    int bad;
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.cpu_wren  = 1'b0;
    bus.cpu_wmask = 4'hA;
    bus.cpu_wdata = 32'h5555AAAA;
    bus.cpu_addr  = 11'h03C;

    // Reset state: loader drives zeros regardless of pipeline inputs.
    @(posedge clk);
    @(negedge clk);
    check("rst_cpu_rstn", bus.cpu_rstn, 0);
    check("rst_wren", bus.mem_wren, 0);
    check("rst_wmask", bus.mem_wmask, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err, 0);
    do_reset();

    // Two-word image.
    send(8'hB5); send(8'h02); send(8'h00);
    @(negedge clk);
    check("load_busy", bus.busy, 1);
    check("load_idle_addr", bus.mem_addr, 0);
    check("load_idle_wren", bus.mem_wren, 0);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    @(negedge clk);
    check("load_w0_wren", bus.mem_wren, 1);
    check("load_w0_addr", bus.mem_addr, 0);
    check("load_w0_data", bus.mem_wdata, 32'h12345678);
    check("load_w0_mask", bus.mem_wmask, 4'hF);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    @(negedge clk);
    check("load_w1_addr", bus.mem_addr, 1);
    check("load_w1_data", bus.mem_wdata, 32'hDEADBEEF);
    check("load_w1_cpu_rstn", bus.cpu_rstn, 0);
    check("load_w1_busy", bus.busy, 1);
    @(posedge clk);
    @(negedge clk);
    check("load_run_cpu_rstn", bus.cpu_rstn, 1);
    check("load_run_busy", bus.busy, 0);
    check("load_run_addr", bus.mem_addr, 11'h03C);
    check("load_nwrites", wr_addr_q.size(), 2);

    // Noise then empty image.
    do_reset();
    send(8'h00); send(8'hFF); send(8'h3C); send(8'hB5); send(8'h00); send(8'h00);
    @(negedge clk);
    check("empty_cpu_rstn_lo", bus.cpu_rstn, 0);
    @(posedge clk);
    @(negedge clk);
    check("empty_cpu_rstn_hi", bus.cpu_rstn, 1);
    check("empty_nwrites", wr_addr_q.size(), 0);

    // Passthrough in RUN; a stray sync byte must not disturb it.
    mon_en = 1'b0;
    bus.cpu_wren  = 1'b1;
    bus.cpu_addr  = 11'h123;
    bus.cpu_wdata = 32'hCAFEF00D;
    bus.cpu_wmask = 4'b0101;
    #1;
    check("pt_wren", bus.mem_wren, 1);
    check("pt_addr", bus.mem_addr, 11'h123);
    check("pt_wdata", bus.mem_wdata, 32'hCAFEF00D);
    check("pt_wmask", bus.mem_wmask, 4'b0101);
    send(8'hB5);
    @(negedge clk);
    check("pt_rx_cpu_rstn", bus.cpu_rstn, 1);
    check("pt_rx_busy", bus.busy, 0);
    bus.cpu_wren = 1'b0;
    bus.cpu_addr = 11'h7FF;
    #1;
    check("pt_wren_lo", bus.mem_wren, 0);
    check("pt_addr2", bus.mem_addr, 11'h7FF);
    bus.cpu_addr  = 11'h03C;
    bus.cpu_wdata = 32'h5555AAAA;
    bus.cpu_wmask = 4'hA;
    mon_en = 1'b1;

    // Overlength image is rejected until rstn.
    do_reset();
    send(8'hB5); send(8'h01); send(8'h08);
    @(negedge clk);
    check("ovl_err", bus.err, 1);
    check("ovl_cpu_rstn", bus.cpu_rstn, 0);
    check("ovl_busy", bus.busy, 0);
    send(8'hB5); send(8'h01); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ovl_nwrites", wr_addr_q.size(), 0);
    check("ovl_err_sticky", bus.err, 1);
    check("ovl_cpu_rstn2", bus.cpu_rstn, 0);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ovl_err_clr", bus.err, 0);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    send(8'hB5); send(8'h00); send(8'h00);
    @(posedge clk);
    @(negedge clk);
    check("ovl_resync_run", bus.cpu_rstn, 1);

    // Reset in the middle of the first word drops it.
    do_reset();
    send(8'hB5); send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_wren", bus.mem_wren, 0);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    send(8'hB5); send(8'h01); send(8'h00);
    send(8'h44); send(8'h33); send(8'h22); send(8'h11);
    @(negedge clk);
    check("mid_w0_addr", bus.mem_addr, 0);
    check("mid_w0_data", bus.mem_wdata, 32'h11223344);
    @(posedge clk);
    @(negedge clk);
    check("mid_run", bus.cpu_rstn, 1);
    check("mid_nwrites", wr_addr_q.size(), 1);

    // Full depth, one byte per cycle.
    do_reset();
    send(8'hB5); send(8'h00); send(8'h08);
    for (int i = 0; i < 2048; i++) begin
      w = img_word(i);
      send(w[7:0]); send(w[15:8]); send(w[23:16]); send(w[31:24]);
    end
    @(negedge clk);
    check("full_last_wren", bus.mem_wren, 1);
    check("full_last_addr", bus.mem_addr, 11'h7FF);
    check("full_last_cpu_rstn", bus.cpu_rstn, 0);
    @(posedge clk);
    @(negedge clk);
    check("full_run", bus.cpu_rstn, 1);
    check("full_busy", bus.busy, 0);
    check("full_nwrites", wr_addr_q.size(), 2048);
    bad = 0;
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      if (wr_addr_q[i] !== 11'(i) || wr_data_q[i] !== img_word(i) || wr_mask_q[i] !== 4'hF)
        bad++;
    end
    check("full_contents_bad", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
